alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID/EX pipeline register that drives the execute-stage ALU.
- Each cycle it:
  - decodes the 2-bit main-control alu_op and the 6-bit funct field into the ALU's 4-bit operation code;
  - resolves operand bypass from the EX/MEM and MEM/WB result buses;
  - selects the register or immediate source for operand2;
  - registers everything with a valid bit.
- Supports stall and flush from the hazard unit.
- Keeps a saturating count of illegal R-type funct codes for debug.

Parameters:
- DATA_W, 32, operand/result width.
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  decoded instruction present at ID.
- stall  in  1  hold all output registers.
- flush  in  1  replace the EX-stage entry with a bubble.
- alu_op  in  2  main-control ALU class.
- funct  in  6  instruction funct field.
- alu_src  in  1  1 = operand2 takes imm, 0 = rt value.
- rs_addr  in  5  source register 1 index.
- rt_addr  in  5  source register 2 index.
- rs_data  in  DATA_W  register-file read port 1.
- rt_data  in  DATA_W  register-file read port 2.
- imm  in  DATA_W  sign-extended immediate.
- exmem_wr  in  1  EX/MEM stage writes a register.
- exmem_rd  in  5  EX/MEM destination register.
- exmem_res  in  DATA_W  EX/MEM result.
- memwb_wr  in  1  MEM/WB stage writes a register.
- memwb_rd  in  5  MEM/WB destination register.
- memwb_res  in  DATA_W  MEM/WB result.
- ex_valid  out  1  EX-stage entry valid.
- operation  out  4  ALU operation code.
- operand1  out  DATA_W  ALU operand 1.
- operand2  out  DATA_W  ALU operand 2.
- illegal  out  1  registered: EX entry carries an unsupported funct.
- illegal_cnt  out  CNT_W  saturating count of illegal entries captured.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - ex_valid, illegal, operand1, operand2 and illegal_cnt all go to 0.
  - operation goes to 4'b0000.
  - Reset overrides stall and flush, including mid-stall.
- Decode (combinational, registered on capture):
  - alu_op 00 → 0010 (ADD, load/store address).
  - alu_op 01 → 0110 (SUB, branch compare).
  - alu_op 11 → 0001 (OR, logical immediate).
  - alu_op 10 selects by funct:
    - 100000 → 0010
    - 100010 → 0110
    - 100100 → 0000
    - 100101 → 0001
    - any other funct → 1111 with illegal = 1.
  - illegal is 0 for every other case.
- Bypass (applied to the value being captured):
  - fwd_rs = exmem_res if exmem_wr and exmem_rd == rs_addr and rs_addr != 0.
  - Otherwise fwd_rs = memwb_res if memwb_wr and memwb_rd == rs_addr and rs_addr != 0.
  - Otherwise fwd_rs = rs_data.
  - fwd_rt is resolved the same way using rt_addr and rt_data.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never bypassed.
- Operand select:
  - operand1 = fwd_rs.
  - operand2 = imm if alu_src = 1, else fwd_rt.
- Register update, in priority order:
  1. rst_n = 0 → reset state as above.
  2. flush = 1 → bubble: ex_valid = 0, illegal = 0, operation = 0000, operands = 0. flush overrides stall.
  3. stall = 1 → all outputs, including illegal_cnt, hold their values.
  4. in_valid = 1 → capture decode and operands; ex_valid = 1.
  5. in_valid = 0 → bubble, same as flush.
- Latency: one cycle from ID inputs to EX outputs.
- illegal_cnt:
  - Increments by 1 on each capture (case 4) with illegal = 1.
  - Saturates at 2^CNT_W − 1.
  - Never increments on a stalled, flushed or bubble cycle.
- A stall that holds an illegal entry does not count it again.

Test Plan:
- Reset: drive garbage inputs with rst_n = 0 for 2 cycles → all outputs 0 and operation = 0000 after the first edge.
- R-type decode: in_valid = 1, alu_op = 10, funct = 100010, rs_data = 9, rt_data = 4, no bypass → next cycle operation = 0110, operand1 = 9, operand2 = 4, ex_valid = 1.
- Bypass priority: rs_addr = 5, exmem_wr = 1, exmem_rd = 5, exmem_res = 0xAA, memwb_wr = 1, memwb_rd = 5, memwb_res = 0xBB → operand1 = 0xAA.
  - With rs_addr = 0 and the same bypass inputs → operand1 = rs_data.
- Immediate path: alu_op = 00, alu_src = 1, imm = 0xFFFFFFFC, rt_addr matching exmem_rd → operation = 0010, operand2 = 0xFFFFFFFC.
- Stall/flush:
  - Capture an entry, then stall = 1 for 3 cycles with changing inputs → outputs frozen.
  - Then stall = 1 and flush = 1 together → ex_valid = 0, operation = 0000.
- Illegal counter:
  - With CNT_W = 2, capture 5 instructions with funct = 000000 and alu_op = 10 → illegal = 1, operation = 1111, illegal_cnt saturates at 3.
  - A stalled illegal entry is not re-counted.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// ID-to-EX bundle for the ALU issue stage: decoded instruction, bypass buses
// and hazard controls in; registered EX-stage operands and status out.
interface alu_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              alu_src;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              exmem_wr;
    logic [4:0]        exmem_rd;
    logic [DATA_W-1:0] exmem_res;
    logic              memwb_wr;
    logic [4:0]        memwb_rd;
    logic [DATA_W-1:0] memwb_res;
    logic              ex_valid;
    logic [3:0]        operation;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic              illegal;
    logic [CNT_W-1:0]  illegal_cnt;

    modport master (
        output in_valid, stall, flush, alu_op, funct, alu_src,
               rs_addr, rt_addr, rs_data, rt_data, imm,
               exmem_wr, exmem_rd, exmem_res, memwb_wr, memwb_rd, memwb_res,
        input  ex_valid, operation, operand1, operand2, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, stall, flush, alu_op, funct, alu_src,
               rs_addr, rt_addr, rs_data, rt_data, imm,
               exmem_wr, exmem_rd, exmem_res, memwb_wr, memwb_rd, memwb_res,
        output ex_valid, operation, operand1, operand2, illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the execute-stage ALU: opcode decode,
// operand bypass, immediate select, stall/flush and an illegal-funct counter.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              ex_valid_q,    ex_valid_d;
    logic [3:0]        operation_q,   operation_d;
    logic [DATA_W-1:0] operand1_q,    operand1_d;
    logic [DATA_W-1:0] operand2_q,    operand2_d;
    logic              illegal_q,     illegal_d;
    logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

    logic [3:0]        dec_op_s;
    logic              dec_ill_s;
    logic [DATA_W-1:0] fwd_rs_s;
    logic [DATA_W-1:0] fwd_rt_s;

    // EX/MEM wins over MEM/WB; r0 is hard-wired zero so it is never bypassed.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] rf_val,
        input logic              em_wr,
        input logic [4:0]        em_rd,
        input logic [DATA_W-1:0] em_res,
        input logic              mw_wr,
        input logic [4:0]        mw_rd,
        input logic [DATA_W-1:0] mw_res
    );
        logic [DATA_W-1:0] val;
        if (em_wr && (em_rd == addr) && (addr != 5'd0)) begin
            val = em_res;
        end else if (mw_wr && (mw_rd == addr) && (addr != 5'd0)) begin
            val = mw_res;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

    // Main-control class plus funct decode into the ALU operation code.
    always_comb begin
        dec_op_s  = 4'b0000;
        dec_ill_s = 1'b0;
        case (bus.alu_op)
            2'b00: dec_op_s = 4'b0010;
            2'b01: dec_op_s = 4'b0110;
            2'b11: dec_op_s = 4'b0001;
            2'b10: begin
                case (bus.funct)
                    6'b100000: dec_op_s = 4'b0010;
                    6'b100010: dec_op_s = 4'b0110;
                    6'b100100: dec_op_s = 4'b0000;
                    6'b100101: dec_op_s = 4'b0001;
                    default: begin
                        dec_op_s  = 4'b1111;
                        dec_ill_s = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_op_s  = 4'b0000;
                dec_ill_s = 1'b0;
            end
        endcase
    end

    // Operand bypass resolution for both source registers.
    always_comb begin
        fwd_rs_s = fwd_sel(bus.rs_addr, bus.rs_data, bus.exmem_wr, bus.exmem_rd,
                           bus.exmem_res, bus.memwb_wr, bus.memwb_rd, bus.memwb_res);
        fwd_rt_s = fwd_sel(bus.rt_addr, bus.rt_data, bus.exmem_wr, bus.exmem_rd,
                           bus.exmem_res, bus.memwb_wr, bus.memwb_rd, bus.memwb_res);
    end

    // Next-state selection: flush beats stall, stall holds everything, else capture or bubble.
    always_comb begin
        ex_valid_d    = 1'b0;
        operation_d   = 4'b0000;
        operand1_d    = {DATA_W{1'b0}};
        operand2_d    = {DATA_W{1'b0}};
        illegal_d     = 1'b0;
        illegal_cnt_d = illegal_cnt_q;
        if (bus.flush) begin
            illegal_cnt_d = illegal_cnt_q;
        end else if (bus.stall) begin
            ex_valid_d    = ex_valid_q;
            operation_d   = operation_q;
            operand1_d    = operand1_q;
            operand2_d    = operand2_q;
            illegal_d     = illegal_q;
            illegal_cnt_d = illegal_cnt_q;
        end else if (bus.in_valid) begin
            ex_valid_d  = 1'b1;
            operation_d = dec_op_s;
            operand1_d  = fwd_rs_s;
            operand2_d  = bus.alu_src ? bus.imm : fwd_rt_s;
            illegal_d   = dec_ill_s;
            if (dec_ill_s && (illegal_cnt_q != CNT_MAX)) begin
                illegal_cnt_d = illegal_cnt_q + CNT_ONE;
            end else begin
                illegal_cnt_d = illegal_cnt_q;
            end
        end else begin
            illegal_cnt_d = illegal_cnt_q;
        end
    end

    // Pipeline register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            operation_q   <= 4'b0000;
            operand1_q    <= {DATA_W{1'b0}};
            operand2_q    <= {DATA_W{1'b0}};
            illegal_q     <= 1'b0;
            illegal_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_valid_q    <= ex_valid_d;
            operation_q   <= operation_d;
            operand1_q    <= operand1_d;
            operand2_q    <= operand2_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.operation   = operation_q;
    assign bus.operand1    = operand1_q;
    assign bus.operand2    = operand2_q;
    assign bus.illegal     = illegal_q;
    assign bus.illegal_cnt = illegal_cnt_q;
endmodule
